// File: rtl/defog_pkg.sv
// Shared types and constants for the defog divider scheduler.
// Holds the FSM state enum, datapath widths and the t2 clamp helper.
package defog_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DEFOG_DIV_LAT      = 8;
   localparam int DEFOG_DIVIDEND_W   = 12;
   localparam int DEFOG_T_W          = 8;
   localparam int DEFOG_Q_W          = 8;
   localparam int DEFOG_TMIN_DEFAULT = 26;

   function automatic logic [DEFOG_T_W-1:0] t2_effective(
      input logic [DEFOG_T_W-1:0] t2,
      input logic [DEFOG_T_W-1:0] tmin,
      input bit                   en
   );
      return (en && (t2 < tmin)) ? tmin : t2;
   endfunction

endpackage

// File: rtl/defog_div_scheduler_if.sv
// Request and result handshakes between requesters, consumer and scheduler.
// master: requester/consumer side; slave: scheduler side.
interface defog_div_scheduler_if #(
   parameter int NREQ = 3
);
   import defog_pkg::*;

   logic [NREQ-1:0]                  req_valid;
   logic [NREQ-1:0]                  req_ready;
   logic [NREQ*DEFOG_DIVIDEND_W-1:0] req_dividend;
   logic [NREQ*DEFOG_T_W-1:0]        req_t2;
   logic                             res_valid;
   logic                             res_ready;
   logic [DEFOG_Q_W-1:0]             res_quotient;
   logic [1:0]                       res_id;
   logic                             res_ovf;

   modport master (
      output req_valid, req_dividend, req_t2, res_ready,
      input  req_ready, res_valid, res_quotient, res_id, res_ovf
   );

   modport slave (
      input  req_valid, req_dividend, req_t2, res_ready,
      output req_ready, res_valid, res_quotient, res_id, res_ovf
   );

endinterface

// File: rtl/defog_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1
// with wrap and returns a one-hot grant plus its encoded index.
module defog_rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      last_grant,
   input  logic            enable,
   output logic [NREQ-1:0] grant,
   output logic [1:0]      index
);

   localparam int IW = (NREQ > 2) ? 2 : 1;

   int j;

   // Walk from the farthest slot to the nearest so the nearest wins.
   always_comb begin
      grant = '0;
      index = '0;
      j     = 0;
      if (enable) begin
         for (int k = NREQ; k >= 1; k--) begin
            j = (int'(last_grant) + k) % NREQ;
            if (req[IW'(j)]) begin
               grant        = '0;
               grant[IW'(j)] = 1'b1;
               index        = 2'(j);
            end
         end
      end
   end

endmodule

// File: rtl/defog_div_scheduler.sv
// Shares one pipelined defog divider among NREQ requesters, one op in flight.
// Optional build macro: DEFOG_TMIN_CLAMP_EN (clamp t2 up to TMIN).
module defog_div_scheduler
   import defog_pkg::*;
#(
   parameter int NREQ    = 3,
   parameter int DIV_LAT = DEFOG_DIV_LAT,
   parameter int TMIN    = DEFOG_TMIN_DEFAULT
) (
   input  logic                        clk,
   input  logic                        nrst,
   defog_div_scheduler_if.slave        bus,
   output logic [DEFOG_DIVIDEND_W-1:0] div_dividend,
   output logic [DEFOG_T_W-1:0]        div_t2,
   input  logic [DEFOG_Q_W-1:0]        div_quotient,
   output logic                        busy
);

`ifdef DEFOG_TMIN_CLAMP_EN
   localparam bit CLAMP_EN = 1'b1;
`else
   localparam bit CLAMP_EN = 1'b0;
`endif

   localparam int              CW    = $clog2(DIV_LAT + 1);
   localparam logic [CW-1:0]   LAST  = CW'(DIV_LAT);
   localparam logic [DEFOG_T_W-1:0] T_MIN = DEFOG_T_W'(TMIN);

   state_t                      state_q, state_d;
   logic [CW-1:0]               cnt_q;
   logic [DEFOG_DIVIDEND_W-1:0] dvd_q;
   logic [DEFOG_T_W-1:0]        t2_q;
   logic [1:0]                  id_q;
   logic [1:0]                  last_q;
   logic [DEFOG_Q_W-1:0]        q_q;
   logic                        ovf_q;

   logic [NREQ-1:0]             gnt;
   logic [1:0]                  gidx;
   logic                        arb_en;
   logic                        accept;
   logic                        capture;
   logic                        ovf;
   logic [DEFOG_DIVIDEND_W-1:0] sel_dvd;
   logic [DEFOG_T_W-1:0]        sel_t2;
   logic [DEFOG_T_W-1:0]        t2_eff;

   defog_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req        (bus.req_valid),
      .last_grant (last_q),
      .enable     (arb_en),
      .grant      (gnt),
      .index      (gidx)
   );

   always_comb begin
      sel_dvd = '0;
      sel_t2  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_dvd = bus.req_dividend[i*DEFOG_DIVIDEND_W +: DEFOG_DIVIDEND_W];
            sel_t2  = bus.req_t2[i*DEFOG_T_W +: DEFOG_T_W];
         end
      end
   end

   assign t2_eff  = t2_effective(sel_t2, T_MIN, CLAMP_EN);
   // dividend >= 256*t2 cannot fit an 8-bit quotient; also covers t2 == 0.
   assign ovf     = {4'b0, dvd_q[11:8]} >= t2_q;
   assign accept  = (state_q == IDLE) && (|gnt);
   assign capture = (state_q == RUN) && (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      arb_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            arb_en = nrst;
            if (|gnt) state_d = RUN;
         end
         RUN: begin
            if (cnt_q == LAST) state_d = HOLD;
         end
         HOLD: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cnt_q  <= '0;
         dvd_q  <= '0;
         t2_q   <= '0;
         id_q   <= '0;
         last_q <= 2'(NREQ - 1);
         q_q    <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (accept) begin
            dvd_q  <= sel_dvd;
            t2_q   <= t2_eff;
            id_q   <= gidx;
            last_q <= gidx;
            cnt_q  <= '0;
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (capture) begin
            q_q   <= ovf ? '1 : div_quotient;
            ovf_q <= ovf;
         end
      end
   end

   assign bus.req_ready    = gnt;
   assign bus.res_valid    = (state_q == HOLD);
   assign bus.res_quotient = q_q;
   assign bus.res_id       = id_q;
   assign bus.res_ovf      = ovf_q;
   assign div_dividend     = dvd_q;
   assign div_t2           = t2_q;
   assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_defog_div_scheduler.sv
// Randomized self-checking bench for defog_div_scheduler with a divider
// core model that corrupts its output if its inputs move mid-operation.
module tb_defog_div_scheduler;
   import defog_pkg::*;

   localparam int NREQ = 3;
   localparam int LAT  = DEFOG_DIV_LAT;

   logic        clk;
   logic        nrst;
   logic [11:0] div_dividend;
   logic [7:0]  div_t2;
   logic [7:0]  div_quotient;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int lg     = NREQ - 1;

   defog_div_scheduler_if #(.NREQ(NREQ)) bus ();

   defog_div_scheduler #(.NREQ(NREQ)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .bus          (bus),
      .div_dividend (div_dividend),
      .div_t2       (div_t2),
      .div_quotient (div_quotient),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider core: valid only if every stage saw the same operands.
   logic [11:0] pd [LAT];
   logic [7:0]  pt [LAT];

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) begin
         pd[i] <= pd[i-1];
         pt[i] <= pt[i-1];
      end
      pd[0] <= div_dividend;
      pt[0] <= div_t2;
   end

   always_comb begin
      bit same;
      same = 1'b1;
      for (int i = 1; i < LAT; i++)
         if (pd[i] !== pd[0] || pt[i] !== pt[0]) same = 1'b0;
      if (!same)           div_quotient = 8'hA5;
      else if (pt[0] == 0) div_quotient = 8'h00;
      else                 div_quotient = 8'(pd[0] / pt[0]);
   end

   function automatic void ref_div(
      input  logic [11:0] dv,
      input  logic [7:0]  t,
      output logic [7:0]  q,
      output logic        ovf
   );
      int te;
      te = int'(t);
`ifdef DEFOG_TMIN_CLAMP_EN
      if (te < DEFOG_TMIN_DEFAULT) te = DEFOG_TMIN_DEFAULT;
`endif
      if (int'(dv) >= 256 * te) begin
         q   = 8'hFF;
         ovf = 1'b1;
      end else begin
         q   = 8'(int'(dv) / te);
         ovf = 1'b0;
      end
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (m[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int i = 0; i < NREQ; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // Single-requester transaction; returns the result fields and latency.
   task automatic issue(
      input  int          id,
      input  logic [11:0] dv,
      input  logic [7:0]  t,
      output logic [7:0]  q,
      output logic        ovf,
      output logic [1:0]  rid,
      output int          lat
   );
      int n;
      int e0;
      @(negedge clk);
      bus.req_dividend[id*12 +: 12] = dv;
      bus.req_t2[id*8 +: 8] = t;
      bus.req_valid = '0;
      bus.req_valid[id] = 1'b1;
      #1;
      n = 0;
      while (bus.req_ready == '0 && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (bus.req_ready == '0) begin
         checks++;
         errors++;
         $display("FAIL wait_ready: req_ready=%b required nonzero", bus.req_ready);
      end
      e0 = cyc + 1;
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      lg = id;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!bus.res_valid && n < 40);
      if (!bus.res_valid) begin
         checks++;
         errors++;
         $display("FAIL wait_result: res_valid=0 required 1");
      end
      lat = cyc - e0;
      q   = bus.res_quotient;
      ovf = bus.res_ovf;
      rid = bus.res_id;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.req_valid    = '0;
      bus.req_dividend = '0;
      bus.req_t2       = '0;
      bus.res_ready    = 1'b1;
      nrst = 1'b1;
      #1 nrst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_res_valid: got %b required 0", bus.res_valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy: got %b required 0", busy);
      end
      checks++;
      if (bus.req_ready !== '0) begin
         errors++;
         $display("FAIL rst_req_ready: got %b required 0", bus.req_ready);
      end
      checks++;
      if (div_dividend !== 12'd0 || div_t2 !== 8'd0) begin
         errors++;
         $display("FAIL rst_div: got %0d/%0d required 0/0", div_dividend, div_t2);
      end
      checks++;
      if (bus.res_quotient !== 8'd0 || bus.res_ovf !== 1'b0 || bus.res_id !== 2'd0) begin
         errors++;
         $display("FAIL rst_result: got q=%0d ovf=%b id=%0d required 0/0/0",
                  bus.res_quotient, bus.res_ovf, bus.res_id);
      end
      nrst = 1'b1;
      lg = NREQ - 1;
   endtask

   task automatic test_basic();
      logic [7:0] q;
      logic       ovf;
      logic [1:0] rid;
      int         lat;
      issue(0, 12'd1000, 8'd100, q, ovf, rid, lat);
      checks++;
      if (q !== 8'd10) begin
         errors++;
         $display("FAIL basic_q: got %0d required 10", q);
      end
      checks++;
      if (ovf !== 1'b0 || rid !== 2'd0) begin
         errors++;
         $display("FAIL basic_flags: got ovf=%b id=%0d required 0/0", ovf, rid);
      end
      checks++;
      if (lat !== LAT + 1) begin
         errors++;
         $display("FAIL basic_latency: got %0d required %0d", lat, LAT + 1);
      end
   endtask

   task automatic test_boundary();
      logic [11:0] dvs [6];
      logic [7:0]  ts  [6];
      logic [7:0]  q, eq;
      logic        ovf, eovf;
      logic [1:0]  rid;
      int          lat;
      dvs = '{12'd4095, 12'd4095, 12'd500, 12'd2560, 12'd2559, 12'd0};
      ts  = '{8'd10, 8'd255, 8'd0, 8'd10, 8'd10, 8'd1};
      for (int i = 0; i < 6; i++) begin
         issue(i % NREQ, dvs[i], ts[i], q, ovf, rid, lat);
         ref_div(dvs[i], ts[i], eq, eovf);
         checks++;
         if (q !== eq || ovf !== eovf || rid !== 2'(i % NREQ)) begin
            errors++;
            $display("FAIL bound_%0d: got q=%0d ovf=%b id=%0d required q=%0d ovf=%b id=%0d",
                     i, q, ovf, rid, eq, eovf, i % NREQ);
         end
      end
      issue(0, 12'd500, 8'd0, q, ovf, rid, lat);
      checks++;
`ifdef DEFOG_TMIN_CLAMP_EN
      if (q !== 8'd19 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL t2_zero: got q=%0d ovf=%b required 19/0", q, ovf);
      end
`else
      if (q !== 8'd255 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL t2_zero: got q=%0d ovf=%b required 255/1", q, ovf);
      end
`endif
   endtask

   task automatic test_random();
      logic [NREQ-1:0] mask;
      logic [11:0]     dv [NREQ];
      logic [7:0]      t  [NREQ];
      logic [7:0]      eq;
      logic            eovf;
      int              exp, e0, n;
      for (int it = 0; it < 24; it++) begin
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            dv[i] = 12'($urandom_range(0, 4095));
            t[i]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 20))
                                                : 8'($urandom_range(0, 255));
         end
         @(negedge clk);
         for (int i = 0; i < NREQ; i++) begin
            bus.req_dividend[i*12 +: 12] = dv[i];
            bus.req_t2[i*8 +: 8] = t[i];
         end
         bus.req_valid = mask;
         #1;
         exp = rr_pick(mask, lg);
         checks++;
         if (bus.req_ready !== NREQ'(1 << exp)) begin
            errors++;
            $display("FAIL rand_grant_%0d: got %b required %b", it,
                     bus.req_ready, NREQ'(1 << exp));
         end
         e0 = cyc + 1;
         @(posedge clk);
         #1;
         bus.req_valid = '0;
         lg = exp;
         ref_div(dv[exp], t[exp], eq, eovf);
         n = 0;
         do begin
            @(negedge clk);
            #1;
            n++;
         end while (!bus.res_valid && n < 40);
         checks++;
         if (!bus.res_valid || cyc - e0 != LAT + 1 ||
             bus.res_quotient !== eq || bus.res_ovf !== eovf ||
             bus.res_id !== 2'(exp)) begin
            errors++;
            $display("FAIL rand_res_%0d: got v=%b lat=%0d q=%0d ovf=%b id=%0d required lat=%0d q=%0d ovf=%b id=%0d",
                     it, bus.res_valid, cyc - e0, bus.res_quotient, bus.res_ovf,
                     bus.res_id, LAT + 1, eq, eovf, exp);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_back_to_back();
      int ids [4];
      int at  [4];
      int ng, n, exp;
      @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      lg = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_dividend[i*12 +: 12] = 12'(1000 + 7 * i);
         bus.req_t2[i*8 +: 8] = 8'(100 + i);
      end
      bus.req_valid = '1;
      bus.res_ready = 1'b1;
      ng = 0;
      n  = 0;
      while (ng < 4 && n < 80) begin
         #1;
         if (bus.req_ready != '0) begin
            ids[ng] = onehot_idx(bus.req_ready);
            at[ng]  = cyc + 1;
            ng++;
         end
         @(negedge clk);
         n++;
      end
      bus.req_valid = '0;
      checks++;
      if (ng != 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d grants required 4", ng);
      end
      for (int i = 0; i < ng; i++) begin
         exp = rr_pick('1, lg);
         lg  = exp;
         checks++;
         if (ids[i] != exp) begin
            errors++;
            $display("FAIL b2b_order_%0d: got %0d required %0d", i, ids[i], exp);
         end
         if (i > 0) begin
            checks++;
            if (at[i] - at[i-1] != LAT + 3) begin
               errors++;
               $display("FAIL b2b_gap_%0d: got %0d required %0d", i,
                        at[i] - at[i-1], LAT + 3);
            end
         end
      end
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_drain: busy=%b required 0", busy);
      end
   endtask

   task automatic test_hold_stall();
      logic [7:0] q, eq;
      logic       ovf, eovf;
      logic [1:0] rid;
      int         lat, bad_res, bad_rdy;
      bus.res_ready = 1'b0;
      issue(2, 12'd3000, 8'd200, q, ovf, rid, lat);
      ref_div(12'd3000, 8'd200, eq, eovf);
      checks++;
      if (q !== eq || ovf !== eovf || rid !== 2'd2) begin
         errors++;
         $display("FAIL stall_res: got q=%0d ovf=%b id=%0d required %0d/%b/2",
                  q, ovf, rid, eq, eovf);
      end
      bus.req_valid = 3'b011;
      bad_res = 0;
      bad_rdy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (bus.res_valid !== 1'b1 || bus.res_quotient !== q ||
             bus.res_ovf !== ovf || bus.res_id !== rid) bad_res++;
         if (bus.req_ready !== '0) bad_rdy++;
      end
      checks++;
      if (bad_res != 0) begin
         errors++;
         $display("FAIL stall_stable: got %0d unstable cycles required 0", bad_res);
      end
      checks++;
      if (bad_rdy != 0) begin
         errors++;
         $display("FAIL stall_ready: got %0d cycles with grant required 0", bad_rdy);
      end
      bus.req_valid = '0;
      bus.res_ready = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (bus.res_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got v=%b busy=%b required 0/0",
                  bus.res_valid, busy);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] eq;
      logic       eovf;
      int         e0, n;
      @(negedge clk);
      bus.req_dividend[12 +: 12] = 12'd2000;
      bus.req_t2[8 +: 8] = 8'd50;
      bus.req_valid = 3'b010;
      repeat (5) @(posedge clk);
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.req_ready !== '0) begin
         errors++;
         $display("FAIL mid_rst_ctrl: got busy=%b v=%b rdy=%b required 0/0/0",
                  busy, bus.res_valid, bus.req_ready);
      end
      checks++;
      if (div_dividend !== 12'd0 || div_t2 !== 8'd0) begin
         errors++;
         $display("FAIL mid_rst_div: got %0d/%0d required 0/0", div_dividend, div_t2);
      end
      @(negedge clk);
      nrst = 1'b1;
      lg = NREQ - 1;
      #1;
      checks++;
      if (bus.req_ready !== 3'b010) begin
         errors++;
         $display("FAIL mid_regrant: got %b required 010", bus.req_ready);
      end
      e0 = cyc + 1;
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      lg = 1;
      ref_div(12'd2000, 8'd50, eq, eovf);
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!bus.res_valid && n < 40);
      checks++;
      if (!bus.res_valid || cyc - e0 != LAT + 1 || bus.res_quotient !== eq ||
          bus.res_ovf !== eovf || bus.res_id !== 2'd1) begin
         errors++;
         $display("FAIL mid_result: got v=%b lat=%0d q=%0d ovf=%b id=%0d required lat=%0d q=%0d ovf=%b id=1",
                  bus.res_valid, cyc - e0, bus.res_quotient, bus.res_ovf,
                  bus.res_id, LAT + 1, eq, eovf);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_random();
      test_back_to_back();
      test_hold_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/defog_div_scheduler.md
# defog_div_scheduler

Sequences the shared 8-stage pipelined defog divider (quotient = dividend / t2, 12-bit by 8-bit) among NREQ channel requesters, typically the R, G and B recovery paths. The divider core samples its dividend input at every pipeline stage, so the scheduler holds dividend and t2 constant for the full pipeline latency and keeps exactly one division in flight. The block also arbitrates round-robin between requesters, saturates overflowing quotients, and returns tagged results over a valid/ready interface.

## Interface
- NREQ, 3, number of requesters (2..4)
- DIV_LAT, 8, divider core latency in clock edges
- TMIN, 26, minimum transmission t2 applied when clamp is compiled in
- clk  in  1  clock
- nrst  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant; one-hot or zero
- req_dividend  in  NREQ*12  packed dividends, requester i at [12i+11:12i]
- req_t2  in  NREQ*8  packed divisors, requester i at [8i+7:8i]
- div_dividend  out  12  to divider core
- div_t2  out  8  to divider core
- div_quotient  in  8  from divider core
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_quotient  out  8  result (saturated)
- res_id  out  2  index of the requester that owns the result
- res_ovf  out  1  result was saturated
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - If any req_valid is high, the arbiter picks index g and raises req_ready[g] combinationally.
  - The handshake completes on that edge, called E0.
  - At E0, dividend and t2_eff are latched into hold registers, id is latched as g, cnt is cleared to 0, and the FSM moves to RUN.
- Arbitration: round-robin. The winner is the first index with req_valid set, searching upward (with wrap) from last_grant+1. last_grant updates only on a completed handshake.
- t2_eff: max(req_t2, TMIN) with clamp compiled in; otherwise req_t2 unchanged.
- div_dividend and div_t2 come from the hold registers. They are constant from E0 until the FSM leaves RUN.
- RUN:
  - cnt increments on every edge.
  - On the edge where cnt == DIV_LAT, div_quotient is captured into res_quotient and the FSM moves to HOLD.
  - That capture edge is E0+DIV_LAT+1.
- Overflow rule: if dividend[11:8] >= t2_eff (equivalently dividend >= 256*t2_eff), then res_quotient = 8'hFF and res_ovf = 1. Otherwise res_quotient = div_quotient and res_ovf = 0.
- t2_eff = 0 (clamp compiled out) always satisfies the overflow rule, so the result is 255 with res_ovf set. No divide-by-zero value ever propagates.
- HOLD:
  - res_valid is 1. res_quotient, res_id and res_ovf stay stable until res_valid & res_ready.
  - On that handshake the FSM returns to IDLE.
- req_ready is 0 in RUN and HOLD; requests are never accepted while an operation is outstanding.

## Timing
- Reset values:
  - State IDLE; cnt, hold registers, div_dividend, div_t2 all 0.
  - res_valid, res_quotient, res_id, res_ovf, busy all 0; req_ready all 0.
  - last_grant = NREQ-1, so requester 0 has priority first.
- Latency: res_valid rises DIV_LAT+1 cycles after the accept edge E0 (9 cycles at default).
- Throughput, with res_ready tied high and requests pending: one accept per DIV_LAT+3 cycles (11 at default).
- Reset asserted mid-operation: immediate return to reset values. The in-flight result is dropped, and the requester must keep req_valid high to be re-served.
- A requester that drops req_valid before it is granted is simply skipped; no error is raised.

## Configuration
- DEFOG_TMIN_CLAMP_EN defined: t2_eff = max(req_t2, TMIN).
- DEFOG_TMIN_CLAMP_EN undefined: t2_eff = req_t2, and t2 = 0 yields a saturated result (255, res_ovf = 1).

## Structure
- defog_pkg holds:
  - the state enum (IDLE, RUN, HOLD);
  - DEFOG_DIV_LAT = 8, DEFOG_DIVIDEND_W = 12, DEFOG_T_W = 8, DEFOG_Q_W = 8;
  - DEFOG_TMIN_DEFAULT = 26.
- One sub-module: defog_rr_arbiter.
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant and encoded index; purely combinational.
- The FSM, counter, hold registers and saturation logic live in defog_div_scheduler.

## Test plan
- Requester 0, dividend 1000, t2 100 -> res_quotient 10, res_id 0, res_ovf 0; res_valid rises 9 cycles after accept.
- All three requesters held valid, res_ready high -> grants in order 0, 1, 2, 0, with accepts exactly 11 cycles apart.
- Dividend 4095, t2 10 -> res_quotient 255, res_ovf 1. Dividend 4095, t2 255 -> res_quotient 16, res_ovf 0.
- Dividend 500, t2 0:
  - clamp compiled in -> res_quotient 19, res_ovf 0;
  - clamp compiled out -> res_quotient 255, res_ovf 1.
- res_ready held low for 20 cycles in HOLD -> res_valid and all result fields stable, and req_ready stays all zero.
- nrst pulsed during RUN with cnt = 4 -> all outputs at reset values. The still-valid requester is accepted on the first edge after reset release, and its result arrives 9 cycles later.
